// File: rtl/apb_master_if.sv
// Bus bundle for apb_master: local command/response channel plus the APB request/response signals.
// The master modport is the apb_master view; the slave modport is the view of whatever drives it.
interface apb_master_if #(
  parameter int ADDR_SIZE = 32,
  parameter int MEM_WIDTH = 32,
  parameter int PROT_SIZE = 3
);
  localparam int STRB_SIZE = MEM_WIDTH / 8;

  // Local command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [MEM_WIDTH-1:0] cmd_wdata;
  logic [STRB_SIZE-1:0] cmd_strb;
  logic [PROT_SIZE-1:0] cmd_prot;

  // Local response channel
  logic                 rsp_valid;
  logic [MEM_WIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;

  // APB
  logic                 PSELX;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDR_SIZE-1:0] PADDR;
  logic [MEM_WIDTH-1:0] PWDATA;
  logic [STRB_SIZE-1:0] PSTRB;
  logic [PROT_SIZE-1:0] PPROT;
  logic                 PREADY;
  logic                 PSLVERR;
  logic [MEM_WIDTH-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSELX, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSELX, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_master.sv
// APB master: turns local valid/ready commands into APB SETUP/ACCESS transfers with back-to-back support.
// Optional macro APB_MASTER_TIMEOUT_EN aborts a transfer after TIMEOUT_CYCLES consecutive wait states.
module apb_master #(
  parameter int ADDR_SIZE      = 32,
  parameter int MEM_WIDTH      = 32,
  parameter int PROT_SIZE      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_master_if.master  bus
);
  localparam int STRB_SIZE = MEM_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [MEM_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_SIZE-1:0] pstrb_q, pstrb_d;
  logic [PROT_SIZE-1:0] pprot_q, pprot_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [MEM_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  logic timeout_fire;
  logic cmd_ready;
  logic accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Fires on the last permitted wait state, so the bus sees exactly TIMEOUT_CYCLES ACCESS cycles.
  assign timeout_fire = (state_q == ACCESS) && !bus.PREADY
                        && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                   wait_cnt_q <= '0;
    else if (state_d == SETUP)                      wait_cnt_q <= '0;
    else if ((state_q == ACCESS) && !bus.PREADY)    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end
`else
  logic timeout_unused;
  assign timeout_fire   = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  // Held low during reset so every output reads 0 while PRESETn is asserted.
  assign cmd_ready = PRESETn && ((state_q == IDLE) ||
                                 ((state_q == ACCESS) && bus.PREADY && !timeout_fire));
  assign accept    = bus.cmd_valid && cmd_ready;

  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (timeout_fire) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (bus.PREADY) begin
          state_d       = accept ? SETUP : IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reads never expose stale write data or strobes on the bus.
    if (accept) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pprot_d  = bus.cmd_prot;
      pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
      pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.PSELX       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
